// File: rtl/ofs_plat_prim_fifo_rr_enq_arb.sv
// Round-robin, packet-aware arbiter feeding one FIFO enqueue port.
// Each accepted beat is tagged {src_idx, eop, data} and registered one
// cycle before it reaches the FIFO. A source that starts a multi-beat
// packet keeps the grant until it sends its end-of-packet beat.
module ofs_plat_prim_fifo_rr_enq_arb #(
    parameter int N_SOURCES  = 4,
    parameter int DATA_WIDTH = 32,
    localparam int SRC_BITS        = $clog2(N_SOURCES),
    localparam int FIFO_DATA_WIDTH = DATA_WIDTH + 1 + SRC_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_SOURCES-1:0]            in_valid,
    input  logic [N_SOURCES*DATA_WIDTH-1:0] in_data,
    input  logic [N_SOURCES-1:0]            in_eop,
    output logic [N_SOURCES-1:0]            in_ready,
    output logic                            fifo_enq_en,
    output logic [FIFO_DATA_WIDTH-1:0]      fifo_enq_data,
    input  logic                            fifo_almostFull,
    input  logic                            fifo_notFull,
    output logic [SRC_BITS-1:0]             cur_owner,
    output logic                            locked
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [SRC_BITS-1:0]         ptr_q, ptr_d;
    logic [SRC_BITS-1:0]         owner_q, owner_d;
    logic                        enq_en_q, enq_en_d;
    logic [FIFO_DATA_WIDTH-1:0]  enq_data_q, enq_data_d;

    logic                        canAccept;
    logic                        anyValid;
    logic [SRC_BITS-1:0]         winner;
    logic [SRC_BITS-1:0]         accSrc;
    logic                        accept;
    logic                        accEop;
    logic [DATA_WIDTH-1:0]       accData;
    logic [SRC_BITS-1:0]         nextPtr;

    // almostFull leaves room for the one beat sitting in the output register
    assign canAccept = !fifo_almostFull && fifo_notFull && !reset;

    // Find the first valid source at or above the pointer, wrapping around
    always_comb begin
        int unsigned idx;
        idx      = 0;
        winner   = '0;
        anyValid = 1'b0;
        for (int i = 0; i < N_SOURCES; i++) begin
            idx = ptr_q + i;
            if (idx >= N_SOURCES) begin
                idx = idx - N_SOURCES;
            end
            if (!anyValid && in_valid[idx]) begin
                anyValid = 1'b1;
                winner   = SRC_BITS'(idx);
            end
        end
    end

    // Grant a single source: the round-robin winner, or the packet owner when locked
    always_comb begin
        in_ready = '0;
        accSrc   = winner;
        if (state_q == ST_LOCKED) begin
            accSrc            = owner_q;
            in_ready[owner_q] = canAccept;
        end else if (canAccept && anyValid) begin
            in_ready[winner] = 1'b1;
        end
    end

    assign accept  = |(in_valid & in_ready);
    assign accEop  = in_eop[accSrc];
    assign accData = in_data[accSrc*DATA_WIDTH +: DATA_WIDTH];
    assign nextPtr = (accSrc == SRC_BITS'(N_SOURCES - 1)) ? '0 : accSrc + 1'b1;

    // Next-state: lock on a non-final beat, release and rotate priority on eop
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        enq_en_d   = accept;
        enq_data_d = enq_data_q;
        if (accept) begin
            enq_data_d = {accSrc, accEop, accData};
            if (accEop) begin
                state_d = ST_ARB;
                ptr_d   = nextPtr;
            end else begin
                state_d = ST_LOCKED;
                owner_d = accSrc;
            end
        end
    end

    // State and output registers; reset drops any beat waiting to be enqueued
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            enq_en_q   <= 1'b0;
            enq_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            enq_en_q   <= enq_en_d;
            enq_data_q <= enq_data_d;
        end
    end

    assign fifo_enq_en   = enq_en_q;
    assign fifo_enq_data = enq_data_q;
    assign cur_owner     = owner_q;
    assign locked        = (state_q == ST_LOCKED);

    // An enqueue into a full FIFO means almostFull was set up too late
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(fifo_enq_en && !fifo_notFull))
                else $fatal(1, "fifo_enq_en asserted while FIFO is full");
        end
    end

endmodule

// File: tb/tb_ofs_plat_prim_fifo_rr_enq_arb.sv
// Directed and randomized bench for the round-robin enqueue arbiter,
// checked every cycle against a packet-level reference model.
module tb_ofs_plat_prim_fifo_rr_enq_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SB = 2;
    localparam int FW = DW + 1 + SB;

    logic              clk;
    logic              reset;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_eop;
    logic [N-1:0]      in_ready;
    logic              fifo_enq_en;
    logic [FW-1:0]     fifo_enq_data;
    logic              fifo_almostFull;
    logic              fifo_notFull;
    logic [SB-1:0]     cur_owner;
    logic              locked;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: priority pointer, packet lock, pending enqueue
    int            mPtr;
    int            mOwner;
    bit            mLocked;
    bit            mEn;
    logic [FW-1:0] mData;

    ofs_plat_prim_fifo_rr_enq_arb #(
        .N_SOURCES (N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_eop         (in_eop),
        .in_ready       (in_ready),
        .fifo_enq_en    (fifo_enq_en),
        .fifo_enq_data  (fifo_enq_data),
        .fifo_almostFull(fifo_almostFull),
        .fifo_notFull   (fifo_notFull),
        .cur_owner      (cur_owner),
        .locked         (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the model's expectation
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] e,
                                 input logic af, input logic nf, input logic rst);
        logic [N-1:0] expReady;
        int           src;
        bit           found;
        bit           acc;
        in_valid        = v;
        in_eop          = e;
        in_data         = {$urandom, $urandom, $urandom, $urandom};
        fifo_almostFull = af;
        fifo_notFull    = nf;
        reset           = rst;
        @(negedge clk);
        expReady = '0;
        src      = 0;
        found    = 0;
        if (!rst && !af && nf) begin
            if (mLocked) begin
                expReady[mOwner] = 1'b1;
                src              = mOwner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int s;
                    s = (mPtr + k) % N;
                    if (!found && v[s]) begin
                        found       = 1;
                        expReady[s] = 1'b1;
                        src         = s;
                    end
                end
            end
        end
        acc = |(expReady & v);
        checkOutput("in_ready", 64'(in_ready), 64'(expReady));
        checkOutput("enq_en", 64'(fifo_enq_en), 64'(mEn));
        if (mEn) checkOutput("enq_data", 64'(fifo_enq_data), 64'(mData));
        checkOutput("locked", 64'(locked), 64'(mLocked));
        if (mLocked) checkOutput("cur_owner", 64'(cur_owner), 64'(mOwner));
        if (rst) begin
            mPtr    = 0;
            mLocked = 0;
            mOwner  = 0;
            mEn     = 0;
            mData   = '0;
        end else begin
            mEn = acc;
            if (acc) begin
                mData = {SB'(src), in_eop[src], in_data[src*DW +: DW]};
                if (in_eop[src]) begin
                    mLocked = 0;
                    mPtr    = (src + 1) % N;
                end else begin
                    mLocked = 1;
                    mOwner  = src;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] rv;
        logic [N-1:0] re;
        logic         raf;
        logic         rnf;
        logic         rrst;

        in_valid        = '1;
        in_eop          = '1;
        in_data         = '0;
        fifo_almostFull = 1'b0;
        fifo_notFull    = 1'b1;
        reset           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mPtr    = 0;
        mOwner  = 0;
        mLocked = 0;
        mEn     = 0;
        mData   = '0;

        // Reset values, observed while reset is still held
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_enq_en", 64'(fifo_enq_en), 64'd0);
        checkOutput("rst_enq_data", 64'(fifo_enq_data), 64'd0);
        checkOutput("rst_locked", 64'(locked), 64'd0);
        checkOutput("rst_cur_owner", 64'(cur_owner), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1);

        // All sources sending single-beat packets: grants rotate 0,1,2,3,0
        repeat (5) applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);

        // Source 1 three-beat packet holds off continuously valid source 2
        applyStimulus(4'b0110, 4'b0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0110, 4'b0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0110, 4'b0110, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);

        // Locked owner goes idle; other valid sources must stay blocked
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0);
        repeat (5) applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0);

        // almostFull stalls everything; source 0 wins first once released
        applyStimulus(4'b1001, 4'b1001, 1'b0, 1'b1, 1'b1);
        repeat (4) applyStimulus(4'b1001, 4'b1001, 1'b1, 1'b1, 1'b0);
        repeat (2) applyStimulus(4'b1001, 4'b1001, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a source 2 packet, then source 0 wins
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1);
        applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b1, 1'b0);

        // Pointer at 3: source 3 then wrap to source 0
        applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b1001, 4'b1001, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b1001, 4'b1001, 1'b0, 1'b1, 1'b0);

        // notFull low blocks acceptance even without almostFull
        applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);

        // Random traffic; notFull only drops when nothing is being enqueued
        for (int n = 0; n < 1500; n++) begin
            rv   = N'($urandom);
            re   = N'($urandom);
            raf  = ($urandom % 5) == 0;
            rnf  = mEn ? 1'b1 : (($urandom % 4) != 0);
            rrst = ($urandom % 100) == 0;
            applyStimulus(rv, re, raf, rnf, rrst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
